// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, engine state encoding and the S-box tables.
// The inverse table is derived from the forward one at elaboration time.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Entry b sits at bits [2047-8b -: 8], row 0 first.
    localparam logic [2047:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [2047:0] gen_inv_sbox();
        logic [2047:0] t;
        logic [7:0]    f;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            f = FWD_SBOX[2047 - 8 * i -: 8];
            t[2047 - 8 * int'(f) -: 8] = 8'(i);
        end
        return t;
    endfunction

    localparam logic [2047:0] INV_SBOX = gen_inv_sbox();

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return FWD_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lookup lane.
// With INV_SBOX_EN defined the lane also carries the inverse table, chosen by inv.
module sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);

`ifdef INV_SBOX_EN
    assign dout = inv ? sbox_inv(din) : sbox_fwd(din);
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign dout       = sbox_fwd(din);
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes: LANES bytes per clock with valid/ready handshakes on both sides.
// Define INV_SBOX_EN to enable the inverse S-box mode selected by in_inv.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam int unsigned N  = AES_BYTES / LANES;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = LANES * 8;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gen_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    aes_state_e             state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [AES_BLOCK_W-1:0] work_q, work_d;
    logic                   mode_q;
    logic                   accept;
    logic [31:0]            hi;
    logic [CW-1:0]          chunk_in, chunk_out;

    assign accept = (state_q == IDLE) && in_valid;

    // Chunk k occupies bytes k*LANES.., counted from the MSB end.
    assign hi       = AES_BLOCK_W - 1 - 32'(k_q) * CW;
    assign chunk_in = work_q[hi -: CW];

    for (genvar j = 0; j < LANES; j++) begin : gen_lane
        sbox_lane u_lane (
            .din  (chunk_in[CW - 1 - 8 * j -: 8]),
            .inv  (mode_q),
            .dout (chunk_out[CW - 1 - 8 * j -: 8])
        );
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    k_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d[hi -: CW] = chunk_out;
                if (k_q == KW'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
        end
    end

`ifdef INV_SBOX_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (accept) begin
            mode_q <= in_inv;
        end
    end
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign mode_q        = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_data  = work_q;
    assign busy      = (state_q == BUSY) || (state_q == DONE);

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench: one engine per legal LANES value, all fed the same stimulus.
// Expected values come from constants and an independent GF(2^8) S-box model.
module tb_sub_bytes_engine;

    localparam int NDUT = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_inv = 1'b0;
    logic         out_ready = 1'b0;

    logic         in_ready_w  [NDUT];
    logic         out_valid_w [NDUT];
    logic [127:0] out_data_w  [NDUT];
    logic         busy_w      [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        sub_bytes_engine #(.LANES(1 << g)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .in_data   (in_data),
            .in_inv    (in_inv),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out_data  (out_data_w[g]),
            .busy      (busy_w[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] iv, s;
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            end
            s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
                ^ {iv[3:0], iv[7:4]} ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] din, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        logic         m;
`ifdef INV_SBOX_EN
        m = inv;
`else
        m = 1'b0 & inv;
`endif
        for (int i = 0; i < 16; i++) begin
            b = din[127 - 8 * i -: 8];
            r[127 - 8 * i -: 8] = m ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Accept one block, toggle in_inv while in flight, hold out_ready low until all finish.
    task automatic run_vec(input string name, input logic [127:0] din, input logic inv,
                           input logic [127:0] exp, output logic [127:0] got0);
        int lat [NDUT];
        bool_loop: begin end
        in_valid  = 1'b1;
        in_data   = din;
        in_inv    = inv;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_data  = rnd128();
        for (int d = 0; d < NDUT; d++) lat[d] = -1;
        for (int c = 1; c <= 40; c++) begin
            in_inv = ~in_inv;
            tick();
            for (int d = 0; d < NDUT; d++) begin
                if (out_valid_w[d] && lat[d] < 0) lat[d] = c;
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s L%0d latency", name, 1 << d), 128'(lat[d]), 128'(16 >> d));
            check($sformatf("%s L%0d data", name, 1 << d), out_data_w[d], exp);
            check($sformatf("%s L%0d in_ready", name, 1 << d), 128'(in_ready_w[d]), 128'(0));
        end
        got0 = out_data_w[0];
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s L%0d drained", name, 1 << d),
                  {125'(0), out_valid_w[d], busy_w[d], in_ready_w[d]}, 128'b001);
        end
    endtask

    typedef struct {
        string        name;
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [7];
    logic [127:0] got;
    logic [127:0] hold;
    logic [127:0] exp_ii;
    int           prev [NDUT];
    int           ngap [NDUT];

    initial begin
        build_tables();

        #1;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("in_ready during rst L%0d", 1 << d), 128'(in_ready_w[d]), 128'(0));
        tick();
        tick();
        rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset flags L%0d", 1 << d),
                  {125'(0), out_valid_w[d], busy_w[d], in_ready_w[d]}, 128'b001);
            check($sformatf("reset out_data L%0d", 1 << d), out_data_w[d], 128'(0));
        end

        vecs[0] = '{"fips_fwd", 128'h00112233445566778899aabbccddeeff, 1'b0,
                    128'h638293c31bfc33f5c4eeacea4bc12816};
        vecs[1] = '{"zeros", 128'h0, 1'b0, {16{8'h63}}};
        vecs[2] = '{"ones", {16{8'hff}}, 1'b0, {16{8'h16}}};
`ifdef INV_SBOX_EN
        vecs[3] = '{"fips_inv", 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1,
                    128'h00112233445566778899aabbccddeeff};
        vecs[4] = '{"all63_inv", {16{8'h63}}, 1'b1, {16{8'h00}}};
`else
        vecs[3] = '{"fips_inv", 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1,
                    model(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b0)};
        vecs[4] = '{"all63_inv", {16{8'h63}}, 1'b1, {16{8'hfb}}};
`endif
        vecs[5].name = "rand_fwd";
        vecs[5].din  = rnd128();
        vecs[5].inv  = 1'b0;
        vecs[5].exp  = model(vecs[5].din, 1'b0);
        vecs[6].name = "rand_inv";
        vecs[6].din  = rnd128();
        vecs[6].inv  = 1'b1;
        vecs[6].exp  = model(vecs[6].din, 1'b1);

        for (int v = 0; v < 7; v++) begin
            run_vec(vecs[v].name, vecs[v].din, vecs[v].inv, vecs[v].exp, got);
            if (v == 3) begin
`ifdef INV_SBOX_EN
                check("inv byte0", 128'(got[127:120]), 128'h00);
`else
                check("inv ignored byte0", 128'(got[127:120]), 128'hfb);
`endif
            end
        end

        // Backpressure: result held for 10 cycles, a stray in_valid is ignored.
        in_valid = 1'b1;
        in_data  = 128'h00112233445566778899aabbccddeeff;
        in_inv   = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 3);
            in_data  = rnd128();
            tick();
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("bp c%0d L%0d data", c, 1 << d), out_data_w[d],
                      128'h638293c31bfc33f5c4eeacea4bc12816);
                check($sformatf("bp c%0d L%0d flags", c, 1 << d),
                      {125'(0), out_valid_w[d], busy_w[d], in_ready_w[d]}, 128'b110);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < NDUT; d++)
            check($sformatf("bp after L%0d flags", 1 << d),
                  {125'(0), out_valid_w[d], busy_w[d], in_ready_w[d]}, 128'b001);

        // Reset two chunks into a block.
        in_valid = 1'b1;
        in_data  = rnd128();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("pre-reset L4 busy", 128'(busy_w[2]), 128'(1));
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("midrst L%0d flags", 1 << d),
                  {125'(0), out_valid_w[d], busy_w[d], in_ready_w[d]}, 128'b000);
            check($sformatf("midrst L%0d data", 1 << d), out_data_w[d], 128'(0));
        end
        tick();
        rst = 1'b0;
        #1;
        run_vec("post_rst_zeros", 128'h0, 1'b0, {16{8'h63}}, got);

        // Back-to-back with out_ready and in_valid held high: II = N+2.
        hold   = rnd128();
        exp_ii = model(hold, 1'b0);
        for (int d = 0; d < NDUT; d++) begin
            prev[d] = -1;
            ngap[d] = 0;
        end
        in_valid  = 1'b1;
        in_data   = hold;
        in_inv    = 1'b0;
        out_ready = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick();
            for (int d = 0; d < NDUT; d++) begin
                if (out_valid_w[d]) begin
                    check($sformatf("ii L%0d data", 1 << d), out_data_w[d], exp_ii);
                    if (prev[d] >= 0) begin
                        check($sformatf("ii L%0d gap", 1 << d), 128'(c - prev[d]),
                              128'((16 >> d) + 2));
                        ngap[d]++;
                    end
                    prev[d] = c;
                end
            end
        end
        for (int d = 0; d < NDUT; d++)
            check($sformatf("ii L%0d enough results", 1 << d), 128'(ngap[d] >= 2), 128'(1));
        in_valid = 1'b0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sub_bytes_engine.md
# sub_bytes_engine

Multi-cycle, parametrised AES SubBytes engine that transforms one 128-bit state per transaction through LANES S-box lanes per clock. It replaces the fully parallel 16-instance SubBytes stage where area matters, and adds valid/ready handshakes and an optional inverse S-box mode. It sits between AddRoundKey and ShiftRows in the round datapath.

## Interface
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input block present.
- in_ready  output  1  engine can accept a block.
- in_data  input  128  state; byte i = in_data[127-8i -: 8], byte 0 is the MSB.
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled on acceptance.
- out_valid  output  1  result held on out_data.
- out_ready  input  1  consumer accepts the result.
- out_data  output  128  substituted state, same byte order as in_data.
- busy  output  1  high in BUSY and DONE.

## Operation
- N = 16/LANES chunks; 2-bit state register: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture in_data into the work register, latch in_inv, clear chunk counter k, go to BUSY.
- BUSY: each edge replaces bytes k*LANES .. k*LANES+LANES-1 of the work register with their S-box values; k increments. On the edge where k = N-1, go to DONE. The counter is $clog2(N) bits, minimum 1, and does not wrap within a block.
- DONE: out_valid=1, out_data = work register, stable until out_ready. On out_valid&out_ready, go to IDLE.
- in_ready is high only in IDLE. There is no combinational path from out_ready to in_ready, and in_valid is ignored outside IDLE.
- in_inv changes after acceptance have no effect on the block in flight.
- Reset, at any time including mid-block: state IDLE, k=0, work register 0, latched mode 0. The in-flight block is discarded and no partial result is emitted.
- Reset values: in_ready=1 once rst deasserts (0 while rst is high), out_valid=0, out_data=0, busy=0.

## Timing
- Acceptance edge E0; chunks are processed on edges E1..EN; out_valid is high in the cycle after EN.
- Latency is N edges from acceptance to out_valid: LANES=16 → 1, LANES=4 → 4, LANES=1 → 16.
- With out_ready held high, the initiation interval is N+2 cycles (BUSY N, DONE 1, IDLE 1).
- All outputs are registered or decoded from the state only; out_data comes straight from the work register.

## Configuration
- INV_SBOX_EN defined: each lane contains both forward and inverse tables, selected by the latched mode.
- INV_SBOX_EN undefined: forward table only. in_inv is still a port but is ignored, and the latched mode is tied to 0. An in_inv=1 request produces the forward result.

## Structure
- Shared package aes_pkg: the state enum (IDLE/BUSY/DONE), AES_BLOCK_W=128, AES_BYTES=16, and the forward/inverse S-box constant arrays.
- One sub-module, sbox_lane (8-bit in, inv select, 8-bit out, combinational lookup), instantiated LANES times with a generate loop. The chunk mux selects the in-place bytes by k.

## Test plan
- FIPS-197 forward, LANES=4: in_data=00112233445566778899aabbccddeeff, in_inv=0 → out_data=638293c31bfc33f5c4eeacea4bc12816, out_valid exactly 4 edges after acceptance.
- Inverse (INV_SBOX_EN defined), LANES=1: in_data=638293c31bfc33f5c4eeacea4bc12816, in_inv=1 → out_data=00112233445566778899aabbccddeeff after 16 edges. The same stimulus with the macro undefined → forward-mapped output (0x63→0xFB in byte 0).
- Backpressure: out_ready=0 for 10 cycles in DONE → out_data stable, in_ready=0, and an in_valid pulse is ignored. Raise out_ready → one transfer, then IDLE.
- Reset mid-block: assert rst at k=2 with LANES=4 → out_valid=0 and out_data=0 immediately. A new block of all 0x00 then yields 0x63 in every byte.
- Sweep LANES ∈ {1,2,4,8,16} with random blocks against a reference model → results identical, latency = 16/LANES, back-to-back II = N+2.
- in_inv toggled during BUSY → result uses the mode captured at acceptance.
